// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one parallel-load UART transmitter between
// NUM_REQ byte requesters. Holds a per-requester parity configuration table,
// loads one frame at a time and reports grant, completion and busy timeout.
module uart_tx_arbiter #(
    parameter int DATA_WD      = 8,
    parameter int NUM_REQ      = 4,
    parameter int IDX_W        = 2,
    parameter int BUSY_TIMEOUT = 8
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*DATA_WD-1:0] req_data,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [NUM_REQ-1:0]         done,
    output logic                       err,
    output logic                       ctrl_busy,
    input  logic                       cfg_we,
    input  logic [IDX_W-1:0]           cfg_idx,
    input  logic                       cfg_par_en,
    input  logic                       cfg_par_typ,
    output logic [DATA_WD-1:0]         tx_p_data,
    output logic                       tx_data_valid,
    output logic                       tx_parity_enable,
    output logic                       tx_parity_type,
    input  logic                       tx_busy
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    // Eight bits covers the full 1..255 timeout range.
    localparam int                CNT_W       = 8;
    localparam logic [CNT_W-1:0]  TIMEOUT_VAL = CNT_W'(BUSY_TIMEOUT);
    localparam logic [IDX_W-1:0]  PTR_INIT    = IDX_W'(NUM_REQ - 1);

    state_t             state_reg;
    // Round-robin pointer; after a capture it also names the current winner.
    logic [IDX_W-1:0]   ptr_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [CNT_W-1:0]   cnt_next;

    logic               par_en_tab  [NUM_REQ];
    logic               par_typ_tab [NUM_REQ];
    logic [DATA_WD-1:0] req_bytes   [NUM_REQ];

    logic               pick_found_next;
    logic [IDX_W-1:0]   pick_idx_next;
    logic [IDX_W-1:0]   cand_idx;

    assign cnt_next = cnt_reg + CNT_W'(1);

    // Unpack the requester data bus and build one config-table entry per requester.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign req_bytes[gi] = req_data[gi*DATA_WD +: DATA_WD];

            // Table entry write; the arbiter reads the pre-write value on the same edge.
            always_ff @(posedge CLK) begin
                if (RST) begin
                    par_en_tab[gi]  <= 1'b0;
                    par_typ_tab[gi] <= 1'b0;
                end else if (cfg_we && (cfg_idx == IDX_W'(gi))) begin
                    par_en_tab[gi]  <= cfg_par_en;
                    par_typ_tab[gi] <= cfg_par_typ;
                end
            end
        end
    endgenerate

    // Pick the first asserted requester after the pointer, wrapping around.
    always_comb begin
        pick_found_next = 1'b0;
        pick_idx_next   = '0;
        cand_idx        = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_idx = IDX_W'((int'(ptr_reg) + k) % NUM_REQ);
            if (!pick_found_next && req[cand_idx]) begin
                pick_found_next = 1'b1;
                pick_idx_next   = cand_idx;
            end
        end
    end

    // Frame sequencer: capture, load pulse, wait for busy to rise, wait for idle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg        <= IDLE;
            ptr_reg          <= PTR_INIT;
            cnt_reg          <= '0;
            gnt              <= '0;
            done             <= '0;
            err              <= 1'b0;
            ctrl_busy        <= 1'b0;
            tx_data_valid    <= 1'b0;
            tx_p_data        <= '0;
            tx_parity_enable <= 1'b0;
            tx_parity_type   <= 1'b0;
        end else begin
            // Pulse outputs default low; each is raised for exactly one cycle.
            gnt           <= '0;
            done          <= '0;
            err           <= 1'b0;
            tx_data_valid <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (pick_found_next) begin
                        ptr_reg          <= pick_idx_next;
                        tx_p_data        <= req_bytes[pick_idx_next];
                        tx_parity_enable <= par_en_tab[pick_idx_next];
                        tx_parity_type   <= par_typ_tab[pick_idx_next];
                        // Grant and load pulse are visible during the LOAD cycle.
                        gnt              <= NUM_REQ'(1) << pick_idx_next;
                        tx_data_valid    <= 1'b1;
                        ctrl_busy        <= 1'b1;
                        state_reg        <= LOAD;
                    end
                end
                LOAD: begin
                    cnt_reg   <= '0;
                    state_reg <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    // A rising busy wins over a timeout in the same cycle.
                    if (tx_busy) begin
                        state_reg <= WAIT_DONE;
                    end else begin
                        cnt_reg <= cnt_next;
                        if (cnt_next == TIMEOUT_VAL) begin
                            err       <= 1'b1;
                            ctrl_busy <= 1'b0;
                            state_reg <= IDLE;
                        end
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        done      <= NUM_REQ'(1) << ptr_reg;
                        ctrl_busy <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: a frame-level reference model
// predicts grant order, captured data/parity and outcome; a monitor process
// pops those predictions and compares them against what the DUT presents.
module tb_uart_tx_arbiter;

    localparam int DATA_WD      = 8;
    localparam int NUM_REQ      = 4;
    localparam int IDX_W        = 2;
    localparam int BUSY_TIMEOUT = 8;

    logic                       CLK;
    logic                       RST;
    logic [NUM_REQ-1:0]         req;
    logic [NUM_REQ*DATA_WD-1:0] req_data;
    logic [NUM_REQ-1:0]         gnt;
    logic [NUM_REQ-1:0]         done;
    logic                       err;
    logic                       ctrl_busy;
    logic                       cfg_we;
    logic [IDX_W-1:0]           cfg_idx;
    logic                       cfg_par_en;
    logic                       cfg_par_typ;
    logic [DATA_WD-1:0]         tx_p_data;
    logic                       tx_data_valid;
    logic                       tx_parity_enable;
    logic                       tx_parity_type;
    logic                       tx_busy;

    uart_tx_arbiter #(
        .DATA_WD(DATA_WD), .NUM_REQ(NUM_REQ), .IDX_W(IDX_W), .BUSY_TIMEOUT(BUSY_TIMEOUT)
    ) dut (
        .CLK(CLK), .RST(RST), .req(req), .req_data(req_data), .gnt(gnt), .done(done),
        .err(err), .ctrl_busy(ctrl_busy), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_par_en(cfg_par_en), .cfg_par_typ(cfg_par_typ), .tx_p_data(tx_p_data),
        .tx_data_valid(tx_data_valid), .tx_parity_enable(tx_parity_enable),
        .tx_parity_type(tx_parity_type), .tx_busy(tx_busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // One predicted frame: who wins, what is sent, and how/when it ends.
    typedef struct {
        int         idx;
        logic [7:0] data;
        bit         par_en;
        bit         par_typ;
        bit         timeout;
        int         lat;
    } frame_t;
    typedef struct { int idx; logic [7:0] data; } pend_t;
    typedef struct { int d; int b; } uart_t;

    frame_t exp_q[$];
    pend_t  pend_q[$];
    uart_t  uart_q[$];

    bit m_en [NUM_REQ];
    bit m_typ[NUM_REQ];
    int m_ptr;

    int n_tests = 0;
    int n_fail  = 0;

    bit     inflight = 0;
    frame_t cur;
    int     cur_age = 0;

    int u_wait = 0;
    int u_bcnt = 0;
    int u_b    = 0;
    logic [NUM_REQ-1:0] glitch;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, expv, $time);
        end
    endtask

    function automatic int first_pend(input int i);
        for (int k = 0; k < pend_q.size(); k++)
            if (pend_q[k].idx == i) return k;
        return -1;
    endfunction

    // Each requester holds req and its oldest pending byte until granted.
    task automatic req_drive();
        for (int i = 0; i < NUM_REQ; i++) begin
            int k;
            k = first_pend(i);
            if (k >= 0) begin
                req[i] = 1'b1;
                req_data[i*DATA_WD +: DATA_WD] = pend_q[k].data;
            end else if (glitch[i]) begin
                req[i] = 1'b1;
                req_data[i*DATA_WD +: DATA_WD] = 8'($urandom);
            end else begin
                req[i] = 1'b0;
            end
        end
    endtask

    // Advance one cycle: requesters react to gnt, the UART model to the load pulse.
    task automatic tick();
        @(negedge CLK);
        cfg_we = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            int k;
            k = first_pend(i);
            if (gnt[i] && k >= 0) pend_q.delete(k);
        end
        if (tx_busy) begin
            u_bcnt--;
            if (u_bcnt <= 0) tx_busy = 1'b0;
        end else if (u_wait > 0) begin
            u_wait--;
            if (u_wait == 0) begin
                tx_busy = 1'b1;
                u_bcnt  = u_b;
            end
        end
        if (tx_data_valid && uart_q.size() > 0) begin
            uart_t u;
            u = uart_q.pop_front();
            u_wait = u.d;
            u_b    = u.b;
        end
        // Short-lived request from an idle requester while a frame is in flight.
        glitch = '0;
        if (tx_busy && $urandom_range(0, 5) == 0) begin
            int g;
            g = $urandom_range(0, NUM_REQ - 1);
            if (first_pend(g) < 0) glitch[g] = 1'b1;
        end
        req_drive();
    endtask

    task automatic cfg_write(input int idx, input bit en, input bit typ);
        tick();
        cfg_we      = 1'b1;
        cfg_idx     = IDX_W'(idx);
        cfg_par_en  = en;
        cfg_par_typ = typ;
        m_en[idx]   = en;
        m_typ[idx]  = typ;
    endtask

    // d = cycles from load pulse until busy rises (0 = never), b = busy length.
    task automatic push_frame(input int idx, input logic [7:0] data, input int d, input int b);
        frame_t f;
        pend_t  p;
        uart_t  u;
        f.idx = idx; f.data = data; f.par_en = m_en[idx]; f.par_typ = m_typ[idx];
        f.timeout = (d == 0);
        f.lat = (d == 0) ? BUSY_TIMEOUT + 1 : d + b + 1;
        exp_q.push_back(f);
        p.idx = idx; p.data = data;
        pend_q.push_back(p);
        u.d = d; u.b = b;
        uart_q.push_back(u);
        m_ptr = idx;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() > 0 || inflight || pend_q.size() > 0 || ctrl_busy) && n < 2000) begin
            tick();
            n++;
        end
        check("round_complete", 32'(n < 2000), 32'd1);
        if (n >= 2000) begin
            exp_q.delete(); pend_q.delete(); uart_q.delete();
        end
        tick();
    endtask

    // data_mode: -1 random, -2 0x10+0x11*idx, otherwise the byte itself.
    task automatic run_round(input logic [NUM_REQ-1:0] mask, input int nframes,
                             input int data_mode, input int d_fix, input int b_fix);
        int p;
        p = m_ptr;
        for (int f = 0; f < nframes; f++) begin
            int nxt, d, b;
            logic [7:0] data;
            bit found;
            nxt = p; found = 0;
            for (int s = 1; s <= NUM_REQ; s++) begin
                int c;
                c = (p + s) % NUM_REQ;
                if (!found && mask[c]) begin nxt = c; found = 1; end
            end
            if (data_mode == -1)      data = 8'($urandom);
            else if (data_mode == -2) data = 8'(8'h10 + 8'h11 * nxt);
            else                      data = 8'(data_mode);
            if (d_fix >= 0) begin
                d = d_fix; b = b_fix;
            end else begin
                d = ($urandom_range(0, 6) == 0) ? 0 : $urandom_range(1, BUSY_TIMEOUT);
                b = $urandom_range(1, 12);
            end
            push_frame(nxt, data, d, b);
            p = nxt;
        end
        req_drive();
        wait_idle();
    endtask

    // Monitor: pop the prediction at each load, check the frame until it ends.
    always @(negedge CLK) begin
        if (RST) begin
            inflight = 0;
        end else begin
            if (inflight) cur_age++;
            if (tx_data_valid || gnt != '0) begin
                if (inflight || exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_load: gnt=%b data=%02h, required no load", gnt, tx_p_data);
                end else begin
                    cur = exp_q.pop_front();
                    inflight = 1;
                    cur_age = 0;
                    check("gnt", 32'(gnt), 32'd1 << cur.idx);
                    check("tx_data_valid", 32'(tx_data_valid), 32'd1);
                    check("tx_p_data", 32'(tx_p_data), 32'(cur.data));
                    check("tx_parity_enable", 32'(tx_parity_enable), 32'(cur.par_en));
                    check("tx_parity_type", 32'(tx_parity_type), 32'(cur.par_typ));
                    check("ctrl_busy_load", 32'(ctrl_busy), 32'd1);
                end
            end else if (done != '0 || err) begin
                if (!inflight) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL stray_end: done=%b err=%b, required none", done, err);
                end else begin
                    check("done", 32'(done), cur.timeout ? 32'd0 : (32'd1 << cur.idx));
                    check("err", 32'(err), 32'(cur.timeout));
                    check("latency", 32'(cur_age), 32'(cur.lat));
                    check("ctrl_busy_end", 32'(ctrl_busy), 32'd0);
                    check("hold_end", {22'd0, tx_p_data, tx_parity_enable, tx_parity_type},
                          {22'd0, cur.data, cur.par_en, cur.par_typ});
                    $display("[TB] frame req=%0d data=%02h par_en=%0d par_typ=%0d %s after %0d cycles",
                             cur.idx, cur.data, cur.par_en, cur.par_typ,
                             err ? "timeout" : "done", cur_age);
                    inflight = 0;
                end
            end else if (inflight) begin
                check("hold_mid", {21'd0, tx_p_data, tx_parity_enable, tx_parity_type, ctrl_busy},
                      {21'd0, cur.data, cur.par_en, cur.par_typ, 1'b1});
                if (cur_age > cur.lat) begin
                    check("frame_end_missing", 32'(cur_age), 32'(cur.lat));
                    inflight = 0;
                end
            end
        end
    end

    initial begin
        RST = 1'b1; req = '0; req_data = '0; cfg_we = 1'b0; cfg_idx = '0;
        cfg_par_en = 1'b0; cfg_par_typ = 1'b0; tx_busy = 1'b0; glitch = '0;
        m_ptr = NUM_REQ - 1;
        for (int i = 0; i < NUM_REQ; i++) begin m_en[i] = 0; m_typ[i] = 0; end
        repeat (3) tick();
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_ctrl_busy", 32'(ctrl_busy), 32'd0);
        check("rst_valid", 32'(tx_data_valid), 32'd0);
        check("rst_data", 32'(tx_p_data), 32'd0);
        check("rst_parity", {30'd0, tx_parity_enable, tx_parity_type}, 32'd0);
        tick();
        tick();
        RST = 1'b0;
        tick();

        // All four request at once right after reset: order 0,1,2,3.
        run_round(4'b1111, 4, -2, 2, 3);

        // Single frame, busy high 11 cycles; gnt one cycle after req is sampled.
        cfg_write(0, 0, 0);
        tick();
        push_frame(0, 8'hA3, 1, 11);
        req_drive();
        tick();
        check("req_to_gnt", 32'(gnt), 32'd1);
        check("req_to_valid", 32'(tx_data_valid), 32'd1);
        wait_idle();

        // Parity enabled, odd.
        cfg_write(1, 1, 1);
        tick();
        push_frame(1, 8'hD2, 2, 5);
        req_drive();
        wait_idle();

        // Requesters 0 and 2 held continuously alternate.
        run_round(4'b0101, 6, -1, -1, 0);

        // Busy never rises: timeout. Then busy rising on the last allowed cycle.
        tick();
        push_frame(0, 8'h5A, 0, 0);
        req_drive();
        wait_idle();
        check("idle_after_timeout", 32'(ctrl_busy), 32'd0);
        push_frame(1, 8'h66, BUSY_TIMEOUT, 2);
        req_drive();
        wait_idle();

        // Config write mid-frame, then reset mid-frame.
        cfg_write(2, 0, 1);
        tick();
        push_frame(2, 8'h77, 1, 40);
        req_drive();
        repeat (10) tick();
        check("mid_frame_busy", 32'(ctrl_busy), 32'd1);
        cfg_write(2, 1, 0);
        repeat (3) begin
            tick();
            check("cfg_no_effect", {30'd0, tx_parity_enable, tx_parity_type}, 32'd1);
        end
        RST = 1'b1;
        tx_busy = 1'b0; u_wait = 0; u_bcnt = 0;
        tick();
        check("midrst_outputs", {21'd0, gnt, done, err, ctrl_busy, tx_data_valid},
              32'd0);
        check("midrst_tx", {22'd0, tx_p_data, tx_parity_enable, tx_parity_type}, 32'd0);
        tick();
        RST = 1'b0;
        exp_q.delete(); pend_q.delete(); uart_q.delete();
        m_ptr = NUM_REQ - 1;
        for (int i = 0; i < NUM_REQ; i++) begin m_en[i] = 0; m_typ[i] = 0; end
        tick();
        push_frame(2, 8'h3C, 2, 4);
        req_drive();
        wait_idle();

        // Config write on the arbitration edge uses the old entry; next frame the new one.
        push_frame(3, 8'hE1, 2, 2);
        req_drive();
        cfg_we = 1'b1; cfg_idx = 2'd3; cfg_par_en = 1'b1; cfg_par_typ = 1'b1;
        m_en[3] = 1; m_typ[3] = 1;
        wait_idle();
        push_frame(3, 8'h1E, 2, 2);
        req_drive();
        wait_idle();

        // Randomized rounds.
        for (int r = 0; r < 25; r++) begin
            logic [NUM_REQ-1:0] mask;
            int nc;
            nc = $urandom_range(0, 2);
            for (int c = 0; c < nc; c++)
                cfg_write($urandom_range(0, NUM_REQ - 1), 1'($urandom), 1'($urandom));
            tick();
            mask = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
            run_round(mask, $countones(mask) + $urandom_range(0, 3), -1, -1, 0);
            repeat ($urandom_range(0, 3)) tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
